rgb_to_grayscale_stream: RTL and testbench
==========================================

# rgb_to_grayscale_stream

Parametrised streaming RGB-to-grayscale converter with a valid/ready handshake, run-time selectable conversion mode and frame-boundary tracking. It sits between the camera/pixel source and the Sobel line-buffer front end. It replaces the single-cycle fixed-width converter and adds a two-stage pipeline with backpressure, selectable weights, start/end-of-frame propagation and a per-frame output pixel count.

## Interface
- `PIX_W`, default 8: bits per colour channel and per gray output.
- `CNT_W`, default 16: width of the per-frame pixel counter.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `red_i`, `green_i`, `blue_i` in `PIX_W`: input pixel channels.
- `valid_i` in 1: input pixel valid.
- `sof_i` in 1: input pixel is the first of a frame; qualified by `valid_i`.
- `cam_done_i` in 1: input pixel is the last of a frame; qualified by `valid_i`.
- `ready_o` out 1: converter accepts a pixel this cycle.
- `mode_i` in 2: conversion mode, sampled on the accepted `sof_i` pixel.
- `grayscale_o` out `PIX_W`: gray result.
- `valid_o` out 1: output valid.
- `ready_i` in 1: downstream accepts an output.
- `sof_o` out 1: output pixel is the first of a frame; qualified by `valid_o`.
- `done_o` out 1: one-cycle pulse when the last pixel of a frame transfers at the output.
- `pix_cnt_o` out `CNT_W`: number of pixels output in the current frame.
- `frame_err_o` out 1: sticky error flag; set on `sof_i` mid-frame or a pixel outside a frame.

## Operation
- A pixel is accepted when `valid_i && ready_o`. An output transfers when `valid_o && ready_i`.
- Modes, as members of `gray_mode_e`:
  - 0 LUMA: R·77 + G·150 + B·29.
  - 1 AVG: R·85 + G·86 + B·85.
  - 2 MAX: max(R,G,B).
  - 3 GREEN: G.
- Weighted modes add 128 to the sum, then take bits [`PIX_W`+7:8]. Weights sum to 256, so the result never exceeds 2^`PIX_W`−1; no saturation logic is needed.
- The active mode is latched when the `sof_i` pixel is accepted and is used for all pixels of that frame. A change on `mode_i` mid-frame is ignored.
- Frame FSM has two states, IDLE and IN_FRAME:
  - IDLE → IN_FRAME on an accepted `sof_i`.
  - IN_FRAME → IDLE on an accepted `cam_done_i`.
  - A pixel with both flags set is a one-pixel frame and stays in IDLE.
  - An accepted `sof_i` in IN_FRAME sets `frame_err_o`, restarts the frame and relatches the mode.
  - An accepted pixel without `sof_i` in IDLE sets `frame_err_o`; the pixel is still converted with the last latched mode.
- `frame_err_o` clears only on reset.
- `pix_cnt_o`:
  - Increments on each output transfer.
  - Is loaded with 1 when the transferred pixel carries `sof_o`.
  - Wraps modulo 2^`CNT_W`.
  - Holds its value after `done_o`.
- `sof_i` and `cam_done_i` flags travel with their pixel through the pipeline.

## Timing
- Pipeline:
  - Stage 1 registers the three products (or max/green) plus the flags.
  - Stage 2 registers the rounded sum onto `grayscale_o`.
- Latency is 2 cycles from acceptance to `valid_o` with no stall. Throughput is 1 pixel/clock.
- Stall rule: a stage advances when its downstream slot is empty or draining. `ready_o = ready_i | ~v2 | ~v1`, which is combinational from `ready_i`.
- Output data and flags are held stable while `valid_o && !ready_i`.
- `done_o` is high in the cycle where the `cam_done_i` pixel transfers (`valid_o && ready_i`), and low otherwise.
- Reset values: `valid_o`, `sof_o`, `done_o`, `frame_err_o` = 0; `grayscale_o` = 0; `pix_cnt_o` = 0; latched mode = LUMA; FSM = IDLE.
- While `rst` is low, `ready_o` is forced to 0.
- Reset asserted mid-frame empties the pipeline immediately and drops any in-flight pixels; no `done_o` is produced for them.

## Structure
- Package `rgb_gray_pkg` holds:
  - `gray_mode_e`;
  - the weight constants (77/150/29, 85/86/85);
  - the rounding constant 128;
  - the `frame_state_e` enum.
- Sub-module `gray_weighted_sum` contains the stage-1 multiply/max select and the stage-2 add/round/slice, parametrised by `PIX_W`.
- The top level holds the handshake, flag pipeline, frame FSM and counter.

## Test plan
- LUMA, R=4 G=2 B=16, sof+done on one pixel, `ready_i`=1 → `grayscale_o`=4 two cycles later; `sof_o`=1, `done_o` pulse, `pix_cnt_o`=1.
- Same pixel in AVG/MAX/GREEN → 7 / 16 / 2. White 255,255,255 in LUMA → 255. Black → 0.
- 8-pixel frame with `ready_i` low for 3 cycles mid-stream → no pixel lost or duplicated, `ready_o` low once both stages are full, `pix_cnt_o`=8 at `done_o`.
- `mode_i` changed from LUMA to MAX mid-frame → the rest of the frame stays LUMA; the next frame uses MAX.
- `sof_i` asserted on pixel 3 of a frame → `frame_err_o`=1 (sticky), `pix_cnt_o` restarts at 1 on that pixel's output.
- `rst` low with 2 pixels in flight → `valid_o`=0 and `pix_cnt_o`=0 next cycle, `ready_o`=0 during reset, and a fresh frame after release converts correctly.

Source files
------------

// File: rtl/rgb_gray_pkg.sv
// Shared types and constants for the RGB-to-grayscale stream converter.
package rgb_gray_pkg;

  typedef enum logic [1:0] {
    ModeLuma  = 2'd0,
    ModeAvg   = 2'd1,
    ModeMax   = 2'd2,
    ModeGreen = 2'd3
  } gray_mode_e;

  typedef enum logic {
    StIdle    = 1'b0,
    StInFrame = 1'b1
  } frame_state_e;

  // Channel weights; each set sums to 256 so the rounded result cannot overflow.
  localparam int unsigned LumaWR = 77;
  localparam int unsigned LumaWG = 150;
  localparam int unsigned LumaWB = 29;
  localparam int unsigned AvgWR  = 85;
  localparam int unsigned AvgWG  = 86;
  localparam int unsigned AvgWB  = 85;

  localparam int unsigned RoundConst = 128;

endpackage

// File: rtl/gray_weighted_sum.sv
// Two-stage datapath: stage 1 registers weighted products (or max/green scaled
// by 256), stage 2 registers the rounded sum sliced down to PIX_W bits.
module gray_weighted_sum
  import rgb_gray_pkg::*;
#(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             s1_en_i,
  input  logic             s2_en_i,
  input  gray_mode_e       mode_i,
  input  logic [PIX_W-1:0] red_i,
  input  logic [PIX_W-1:0] green_i,
  input  logic [PIX_W-1:0] blue_i,
  output logic [PIX_W-1:0] gray_o
);

  localparam int unsigned ProdW = PIX_W + 8;

  logic [ProdW-1:0] wr, wg, wb;
  logic [PIX_W-1:0] max_rgb;
  logic [ProdW-1:0] pr_d, pg_d, pb_d;
  logic [ProdW-1:0] pr_q, pg_q, pb_q;
  logic [ProdW-1:0] sum;
  logic [PIX_W-1:0] gray_d, gray_q;

  // Stage-1 product select; non-weighted modes are pre-scaled by 256 so the
  // shared round/slice in stage 2 returns them unchanged.
  always_comb begin
    wr   = '0;
    wg   = '0;
    wb   = '0;
    pr_d = '0;
    pg_d = '0;
    pb_d = '0;
    max_rgb = red_i;
    if (green_i > max_rgb) max_rgb = green_i;
    if (blue_i > max_rgb) max_rgb = blue_i;
    unique case (mode_i)
      ModeLuma: begin
        wr = ProdW'(LumaWR);
        wg = ProdW'(LumaWG);
        wb = ProdW'(LumaWB);
        pr_d = ProdW'(red_i) * wr;
        pg_d = ProdW'(green_i) * wg;
        pb_d = ProdW'(blue_i) * wb;
      end
      ModeAvg: begin
        wr = ProdW'(AvgWR);
        wg = ProdW'(AvgWG);
        wb = ProdW'(AvgWB);
        pr_d = ProdW'(red_i) * wr;
        pg_d = ProdW'(green_i) * wg;
        pb_d = ProdW'(blue_i) * wb;
      end
      ModeMax:   pr_d = ProdW'(max_rgb) << 8;
      ModeGreen: pr_d = ProdW'(green_i) << 8;
      default:   pr_d = '0;
    endcase
  end

  // Weights sum to 256, so the rounded total always fits in ProdW bits.
  always_comb begin
    sum    = pr_q + pg_q + pb_q + ProdW'(RoundConst);
    gray_d = PIX_W'(sum >> 8);
  end

  // Stage-1 product registers, loaded on pixel acceptance.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pr_q <= '0;
      pg_q <= '0;
      pb_q <= '0;
    end else if (s1_en_i) begin
      pr_q <= pr_d;
      pg_q <= pg_d;
      pb_q <= pb_d;
    end
  end

  // Stage-2 result register, loaded when stage 1 moves forward.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gray_q <= '0;
    end else if (s2_en_i) begin
      gray_q <= gray_d;
    end
  end

  assign gray_o = gray_q;

endmodule

// File: rtl/rgb_to_grayscale_stream.sv
// Streaming RGB-to-grayscale converter with valid/ready handshake, per-frame
// mode latching, frame-boundary checking and an output pixel counter.
module rgb_to_grayscale_stream
  import rgb_gray_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PIX_W-1:0] red_i,
  input  logic [PIX_W-1:0] green_i,
  input  logic [PIX_W-1:0] blue_i,
  input  logic             valid_i,
  input  logic             sof_i,
  input  logic             cam_done_i,
  output logic             ready_o,
  input  logic [1:0]       mode_i,
  output logic [PIX_W-1:0] grayscale_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             sof_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pix_cnt_o,
  output logic             frame_err_o
);

  logic v1_q, v1_d, v2_q, v2_d;
  logic sof1_q, done1_q, sof2_q, done2_q;
  logic accept, adv2, s2_load, xfer;
  gray_mode_e   mode_q, mode_d, eff_mode;
  frame_state_e state_q, state_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Handshake: a slot can take data when it is empty or its consumer drains it.
  always_comb begin
    adv2     = ~v2_q | ready_i;
    ready_o  = rst & (ready_i | ~v2_q | ~v1_q);
    accept   = valid_i & ready_o;
    s2_load  = adv2 & v1_q;
    xfer     = v2_q & ready_i;
    v1_d     = accept ? 1'b1 : (adv2 ? 1'b0 : v1_q);
    v2_d     = adv2 ? v1_q : v2_q;
    // A start-of-frame pixel uses the mode presented with it.
    eff_mode = sof_i ? gray_mode_e'(mode_i) : mode_q;
  end

  // Valid bits and flags travelling alongside the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      sof1_q  <= 1'b0;
      done1_q <= 1'b0;
      sof2_q  <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      if (accept) begin
        sof1_q  <= sof_i;
        done1_q <= cam_done_i;
      end
      if (s2_load) begin
        sof2_q  <= sof1_q;
        done2_q <= done1_q;
      end
    end
  end

  gray_weighted_sum #(
    .PIX_W (PIX_W)
  ) u_sum (
    .clk_i   (clk),
    .rst_ni  (rst),
    .s1_en_i (accept),
    .s2_en_i (s2_load),
    .mode_i  (eff_mode),
    .red_i   (red_i),
    .green_i (green_i),
    .blue_i  (blue_i),
    .gray_o  (grayscale_o)
  );

  // Frame FSM next state, mode latch and sticky error.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    err_d   = err_q;
    if (accept) begin
      if (sof_i) begin
        mode_d  = gray_mode_e'(mode_i);
        if (state_q == StInFrame) err_d = 1'b1;
        state_d = cam_done_i ? StIdle : StInFrame;
      end else if (state_q == StIdle) begin
        err_d = 1'b1;
      end else if (cam_done_i) begin
        state_d = StIdle;
      end
    end
  end

  // Frame FSM state, latched mode and error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      mode_q  <= ModeLuma;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
    end
  end

  // Output pixel counter: restarts at 1 on a start-of-frame transfer.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer) cnt_d = sof2_q ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign valid_o     = v2_q;
  assign sof_o       = v2_q & sof2_q;
  assign done_o      = xfer & done2_q;
  assign pix_cnt_o   = cnt_q;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_rgb_to_grayscale_stream.sv
// Scoreboard bench for rgb_to_grayscale_stream: a driver feeds pixels and pushes
// reference results; a monitor pops and compares on every output transfer.
module tb_rgb_to_grayscale_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  red_i = '0, green_i = '0, blue_i = '0;
  logic        valid_i = 1'b0, sof_i = 1'b0, cam_done_i = 1'b0;
  logic        ready_o;
  logic [1:0]  mode_i = '0;
  logic [7:0]  grayscale_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        sof_o, done_o;
  logic [15:0] pix_cnt_o;
  logic        frame_err_o;

  rgb_to_grayscale_stream #(
    .PIX_W (8),
    .CNT_W (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .red_i       (red_i),
    .green_i     (green_i),
    .blue_i      (blue_i),
    .valid_i     (valid_i),
    .sof_i       (sof_i),
    .cam_done_i  (cam_done_i),
    .ready_o     (ready_o),
    .mode_i      (mode_i),
    .grayscale_o (grayscale_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .sof_o       (sof_o),
    .done_o      (done_o),
    .pix_cnt_o   (pix_cnt_o),
    .frame_err_o (frame_err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int gray;
    bit sof;
    bit done;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   exp_cnt  = 0;
  bit   m_in_frame = 0;
  int   m_mode = 0;
  bit   m_err = 0;
  bit   force_low = 0;
  bit   rand_rdy = 0;
  bit   saw_low = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int ref_gray(input int m, input int r, input int g, input int b);
    int mx;
    case (m)
      0: return (77 * r + 150 * g + 29 * b + 128) / 256;
      1: return (85 * r + 86 * g + 85 * b + 128) / 256;
      2: begin
        mx = r;
        if (g > mx) mx = g;
        if (b > mx) mx = b;
        return mx;
      end
      default: return g;
    endcase
  endfunction

  // Frame-level reference: mode belongs to the frame opened by the last sof.
  task automatic model_accept(input int r, input int g, input int b, input bit s,
                              input bit d, input int m);
    exp_t e;
    if (s) begin
      if (m_in_frame) m_err = 1;
      m_mode = m;
      m_in_frame = !d;
    end else if (!m_in_frame) begin
      m_err = 1;
    end else if (d) begin
      m_in_frame = 0;
    end
    e.gray = ref_gray(m_mode, r, g, b);
    e.sof  = s;
    e.done = d;
    q.push_back(e);
  endtask

  task automatic send(input int r, input int g, input int b, input bit s, input bit d,
                      input int m);
    int t = 0;
    bit ok = 0;
    red_i = 8'(r); green_i = 8'(g); blue_i = 8'(b);
    sof_i = s; cam_done_i = d; mode_i = 2'(m); valid_i = 1'b1;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (ready_o) begin
        model_accept(r, g, b, s, d, m);
        ok = 1;
      end
      @(posedge clk);
      #1;
      t++;
    end
    if (!ok) check("send_timeout", 0, 1);
    valid_i = 1'b0;
    sof_i = 1'b0;
    cam_done_i = 1'b0;
  endtask

  task automatic send_frame(input int len, input int m);
    for (int i = 0; i < len; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           i == 0, i == len - 1, m);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || valid_o) && t < 300) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain_queue_empty", q.size(), 0);
  endtask

  // Downstream ready: steady, randomly throttled, or forced low.
  initial forever begin
    @(posedge clk);
    #2;
    if (force_low) ready_i = 1'b0;
    else if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
    else ready_i = 1'b1;
  end

  // Monitor: compares every output transfer against the scoreboard head.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst) begin
      if (!ready_o) saw_low = 1;
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = q.pop_front();
          check("gray", int'(grayscale_o), e.gray);
          check("sof_o", int'(sof_o), int'(e.sof));
          check("done_o", int'(done_o), int'(e.done));
          check("pix_cnt_before", int'(pix_cnt_o), exp_cnt);
          exp_cnt = e.sof ? 1 : (exp_cnt + 1) % 65536;
        end
      end else begin
        check("done_idle", int'(done_o), 0);
      end
    end
  end

  initial begin
    // Reset state.
    #12;
    check("rst_valid_o", int'(valid_o), 0);
    check("rst_ready_o", int'(ready_o), 0);
    check("rst_pix_cnt", int'(pix_cnt_o), 0);
    check("rst_frame_err", int'(frame_err_o), 0);
    check("rst_done_o", int'(done_o), 0);
    check("rst_gray", int'(grayscale_o), 0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-pixel frame in LUMA, with latency check.
    send(4, 2, 16, 1, 1, 0);
    @(negedge clk);
    check("lat_cycle1_valid", int'(valid_o), 0);
    @(negedge clk);
    check("lat_cycle2_valid", int'(valid_o), 1);
    check("lat_cycle2_gray", int'(grayscale_o), 4);
    drain();
    check("cnt_one_pixel", int'(pix_cnt_o), 1);

    // Same pixel in the other modes, then white and black.
    send(4, 2, 16, 1, 1, 1);
    send(4, 2, 16, 1, 1, 2);
    send(4, 2, 16, 1, 1, 3);
    send(255, 255, 255, 1, 1, 0);
    send(0, 0, 0, 1, 1, 0);
    drain();
    check("cnt_after_singles", int'(pix_cnt_o), 1);

    // 8-pixel frame with a 3-cycle downstream stall.
    saw_low = 0;
    fork
      send_frame(8, 0);
      begin
        repeat (4) @(posedge clk);
        #1 force_low = 1;
        repeat (3) @(posedge clk);
        #1 force_low = 0;
      end
    join
    drain();
    check("stall_ready_low_seen", int'(saw_low), 1);
    check("stall_cnt_8", int'(pix_cnt_o), 8);
    check("stall_no_err", int'(frame_err_o), 0);

    // Mode change mid-frame is ignored until the next frame.
    for (int i = 0; i < 6; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           i == 0, i == 5, (i < 3) ? 0 : 2);
    send_frame(4, 2);
    drain();
    check("mode_no_err", int'(frame_err_o), 0);

    // sof on pixel 3 of a frame: sticky error, count restarts.
    for (int i = 0; i < 5; i++)
      send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
           i == 0 || i == 2, i == 4, 1);
    drain();
    check("err_set", int'(frame_err_o), 1);
    check("err_cnt_restart", int'(pix_cnt_o), 3);
    send_frame(3, 3);
    send(10, 200, 30, 0, 0, 0);   // orphan pixel outside any frame
    drain();
    check("err_sticky", int'(frame_err_o), int'(m_err));

    // Reset with two pixels in flight.
    force_low = 1;
    @(posedge clk);
    #3;
    send(50, 60, 70, 1, 0, 0);
    send(80, 90, 100, 0, 0, 0);
    rst = 1'b0;
    q.delete();
    exp_cnt = 0;
    m_in_frame = 0;
    m_mode = 0;
    m_err = 0;
    @(negedge clk);
    check("midrst_valid_o", int'(valid_o), 0);
    check("midrst_pix_cnt", int'(pix_cnt_o), 0);
    check("midrst_ready_o", int'(ready_o), 0);
    check("midrst_err_clear", int'(frame_err_o), 0);
    @(negedge clk);
    rst = 1'b1;
    force_low = 0;
    @(posedge clk);
    #1;
    send_frame(5, 1);
    drain();
    check("postrst_cnt", int'(pix_cnt_o), 5);

    // Randomized frames under random backpressure.
    rand_rdy = 1;
    for (int f = 0; f < 12; f++) send_frame($urandom_range(1, 10), $urandom_range(0, 3));
    send_frame(7, $urandom_range(0, 3));
    drain();
    rand_rdy = 0;
    check("rand_last_cnt", int'(pix_cnt_o), 7);
    check("rand_no_err", int'(frame_err_o), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
